// File: rtl/pulse_scheduler.sv
// pulse_scheduler: periodic pulse / burst generator with handshaked config.
// Ports:
//   clock, reset (sync, active-high)
//   cfg_valid/cfg_ready, cfg_period, cfg_count : config handshake
//   start, stop : burst control levels
//   out : single-cycle pulse, busy : in RUN, done : burst finished
// Optional macro PULSE_SCHED_STATUS_EN adds pulses_left output.
module pulse_scheduler #(
    parameter int PERIOD_W       = 8,
    parameter int COUNT_W        = 8,
    parameter int DEFAULT_PERIOD = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [COUNT_W-1:0]  cfg_count,
    input  logic                start,
    input  logic                stop,
    output logic                out,
    output logic                busy,
    output logic                done
`ifdef PULSE_SCHED_STATUS_EN
    ,
    output logic [COUNT_W-1:0]  pulses_left
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [COUNT_W-1:0]  C_ONE = COUNT_W'(1);

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [PERIOD_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0]    sent_q, sent_d;
    logic [PERIOD_W-1:0]   eff_period;
    logic [COUNT_W-1:0]    sent_inc;

    // A period of 0 is stored as 1; the incoming value also seeds the
    // timer when config and start coincide.
    always_comb begin
        eff_period = period_q;
        if (cfg_valid) begin
            eff_period = (cfg_period == '0) ? P_ONE : cfg_period;
        end
    end

    assign sent_inc = sent_q + C_ONE;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        count_d  = count_q;
        timer_d  = timer_q;
        sent_d   = sent_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    period_d = eff_period;
                    count_d  = cfg_count;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    timer_d = eff_period - P_ONE;
                    sent_d  = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    timer_d = period_q - P_ONE;
                    sent_d  = sent_inc;
                    // count_q==0 is free-run; sent simply wraps
                    if (count_q != '0 && sent_inc == count_q) begin
                        state_d = DONE;
                    end
                end else begin
                    timer_d = timer_q - P_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PULSE_SCHED_STATUS_EN
    logic [COUNT_W-1:0] left_q, left_d;

    always_comb begin
        left_d = '0;
        if (state_d == RUN && count_d != '0) begin
            left_d = count_d - sent_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            left_q <= '0;
        end else begin
            left_q <= left_d;
        end
    end

    assign pulses_left = left_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            period_q <= PERIOD_W'(DEFAULT_PERIOD);
            count_q  <= '0;
            timer_q  <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            sent_q   <= sent_d;
        end
    end

    // Moore outputs decoded from registered state only
    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign out       = (state_q == RUN) && (timer_q == '0);

endmodule
